// File: rtl/fir_ctrl_dbuf.sv
// fir_ctrl_dbuf: laser-channel FIR with a double-buffered coefficient bank.
// Coefficients are fetched into a shadow bank by a small load FSM. They are
// then copied into the active bank in one cycle, at a point where no sample
// is being taken. The data path is three register stages deep: history
// shift, multiply-accumulate, and round/saturate. Bypass and the two flags
// use the same three-stage latency.
//
// Coefficient handshake: fir_tap_para_ren_o is a read strobe and is high for
// exactly N consecutive cycles per load. The source answers each strobe with
// fir_tap_para_vld_i one cycle later. Every vld is taken with no back-pressure.
// Words beyond N are dropped. If fewer than N words arrive within
// LOAD_TIMEOUT cycles after the last strobe, the load is abandoned.
module fir_ctrl_dbuf #(
    parameter int FIR_TAP_WIDTH = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int TAP_NUM_MAX   = 64,
    parameter int COEF_FRAC     = 30,
    parameter int ACC_WIDTH     = 64,
    parameter int TNW           = $clog2(TAP_NUM_MAX + 1),
    parameter int LOAD_TIMEOUT  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     laser_fir_en_i,
    input  logic                     laser_fir_upmode_i,
    input  logic                     laser_start_i,
    input  logic [TNW-1:0]           fir_tap_num_i,
    input  logic                     fir_tap_ready_i,
    output logic                     fir_tap_para_ren_o,
    input  logic                     fir_tap_para_vld_i,
    input  logic [FIR_TAP_WIDTH-1:0] fir_tap_para_data_i,
    input  logic                     encode_zero_flag_i,
    input  logic                     lp_recover_acc_flag_i,
    input  logic                     laser_vld_i,
    input  logic [DATA_WIDTH-1:0]    laser_data_i,
    output logic                     fir_zero_flag_o,
    output logic                     fir_acc_flag_o,
    output logic                     fir_laser_vld_o,
    output logic [DATA_WIDTH-1:0]    fir_laser_data_o,
    output logic                     fir_load_busy_o,
    output logic                     fir_load_err_o,
    output logic [1:0]               fir_load_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int PW = FIR_TAP_WIDTH + DATA_WIDTH;
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    localparam logic signed [ACC_WIDTH-1:0] ROUND_C =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [TNW-1:0] n_load_q, n_load_d;
    logic [TNW-1:0] ren_cnt_q, ren_cnt_d;
    logic [TNW-1:0] wr_cnt_q, wr_cnt_d;
    logic [TNW-1:0] n_act_q, n_act_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;
    logic           pending_q, pending_d;
    logic [TNW-1:0] n_clamp;
    logic           shadow_we;
    logic           swap_go;

    logic signed [FIR_TAP_WIDTH-1:0] shadow_q [TAP_NUM_MAX];
    logic signed [FIR_TAP_WIDTH-1:0] active_q [TAP_NUM_MAX];
    logic signed [DATA_WIDTH-1:0]    hist_q   [TAP_NUM_MAX];

    logic                         start_q;
    logic                         start_rise;
    logic                         vld_s1_q, vld_s2_q, vld_o_q;
    logic [DATA_WIDTH-1:0]        byp_s1_q, byp_s2_q, data_o_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  mac_sum;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  rounded;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]        sat_data;
    logic [2:0]                   zf_q, af_q;

    assign start_rise = laser_start_i & ~start_q;
    assign swap_go    = pending_q & (laser_fir_upmode_i ? ~laser_vld_i : ~laser_start_i);
    assign shadow_we  = fir_tap_para_vld_i && (state_q == ST_READ || state_q == ST_WAIT)
                        && (wr_cnt_q < n_load_q);

    // Clamp the requested tap count into 1..TAP_NUM_MAX
    always_comb begin
        n_clamp = fir_tap_num_i;
        if (fir_tap_num_i == '0)
            n_clamp = TNW'(1);
        else if (fir_tap_num_i > TNW'(TAP_NUM_MAX))
            n_clamp = TNW'(TAP_NUM_MAX);
    end

    // Load FSM next-state, counters, sticky error and swap bookkeeping
    always_comb begin
        state_d   = state_q;
        n_load_d  = n_load_q;
        ren_cnt_d = ren_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        timer_d   = timer_q;
        err_d     = err_q;
        pending_d = pending_q;
        n_act_d   = n_act_q;
        case (state_q)
            ST_IDLE: begin
                if (fir_tap_ready_i && !pending_q) begin
                    state_d   = ST_READ;
                    n_load_d  = n_clamp;
                    ren_cnt_d = '0;
                    wr_cnt_d  = '0;
                    timer_d   = '0;
                end
            end
            ST_READ: begin
                ren_cnt_d = ren_cnt_q + 1'b1;
                if (ren_cnt_q == n_load_q - TNW'(1))
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_cnt_q == n_load_q) begin
                    state_d = ST_DONE;
                end else if (timer_q == TW'(LOAD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                pending_d = 1'b1;
                err_d     = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        if (shadow_we)
            wr_cnt_d = wr_cnt_q + 1'b1;
        if (swap_go) begin
            pending_d = 1'b0;
            n_act_d   = n_load_q;
        end
    end

    // Control registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            n_load_q  <= '0;
            ren_cnt_q <= '0;
            wr_cnt_q  <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            n_act_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_load_q  <= n_load_d;
            ren_cnt_q <= ren_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            n_act_q   <= n_act_d;
        end
    end

    // Shadow bank fill and atomic shadow-to-active copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < TAP_NUM_MAX; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAP_NUM_MAX; k++) begin
                if (shadow_we && wr_cnt_q == TNW'(k))
                    shadow_q[k] <= fir_tap_para_data_i;
                if (swap_go)
                    active_q[k] <= shadow_q[k];
            end
        end
    end

    // Stage 1: sample history; a start rising edge clears it, and a same-cycle sample lands first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q  <= 1'b0;
            vld_s1_q <= 1'b0;
            byp_s1_q <= '0;
            for (int k = 0; k < TAP_NUM_MAX; k++)
                hist_q[k] <= '0;
        end else begin
            start_q  <= laser_start_i;
            vld_s1_q <= laser_vld_i;
            if (laser_vld_i)
                byp_s1_q <= laser_data_i;
            if (start_rise) begin
                for (int k = 0; k < TAP_NUM_MAX; k++)
                    hist_q[k] <= '0;
                if (laser_vld_i)
                    hist_q[0] <= laser_data_i;
            end else if (laser_vld_i) begin
                hist_q[0] <= laser_data_i;
                for (int k = 1; k < TAP_NUM_MAX; k++)
                    hist_q[k] <= hist_q[k-1];
            end
        end
    end

    // Full-precision dot product over the active taps only
    always_comb begin
        mac_sum = '0;
        prod    = '0;
        for (int k = 0; k < TAP_NUM_MAX; k++) begin
            prod = active_q[k] * hist_q[k];
            if (TNW'(k) < n_act_q)
                mac_sum = mac_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        end
    end

    // Stage 2: register the accumulated sum alongside the bypass copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_s2_q <= 1'b0;
            byp_s2_q <= '0;
            acc_q    <= '0;
        end else begin
            vld_s2_q <= vld_s1_q;
            if (vld_s1_q) begin
                byp_s2_q <= byp_s1_q;
                acc_q    <= mac_sum;
            end
        end
    end

    // Round half up, drop the fractional bits, clip to the sample range
    always_comb begin
        rounded  = acc_q + ROUND_C;
        shifted  = rounded >>> COEF_FRAC;
        sat_data = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX)
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
    end

    // Stage 3: output register; flags ride a free-running 3-deep shift
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_o_q  <= 1'b0;
            data_o_q <= '0;
            zf_q     <= '0;
            af_q     <= '0;
        end else begin
            vld_o_q <= vld_s2_q;
            if (vld_s2_q)
                data_o_q <= laser_fir_en_i ? sat_data : byp_s2_q;
            zf_q <= {zf_q[1:0], encode_zero_flag_i};
            af_q <= {af_q[1:0], lp_recover_acc_flag_i};
        end
    end

    assign fir_tap_para_ren_o = (state_q == ST_READ);
    assign fir_load_busy_o    = (state_q != ST_IDLE);
    assign fir_load_err_o     = err_q;
    assign fir_load_state_o   = state_q;
    assign fir_laser_vld_o    = vld_o_q;
    assign fir_laser_data_o   = data_o_q;
    assign fir_zero_flag_o    = zf_q[2];
    assign fir_acc_flag_o     = af_q[2];

endmodule
